// File: rtl/sram_pkg.sv
// Shared types and geometry helpers for the tiled 1RW SRAM wrapper.
// Lists the hard-macro shapes the library provides and the wrapper FSM states.
package sram_pkg;

  localparam int N_LEGAL_AW = 4;
  localparam int N_LEGAL_DW = 2;
  localparam int LEGAL_AW [N_LEGAL_AW] = '{12, 11, 9, 4};
  localparam int LEGAL_DW [N_LEGAL_DW] = '{8, 16};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  // True when an SRAM1RW<2**aw>x<dw> macro exists in the library.
  function automatic bit legal_macro(input int aw, input int dw);
    bit aw_ok;
    bit dw_ok;
    aw_ok = 1'b0;
    dw_ok = 1'b0;
    for (int i = 0; i < N_LEGAL_AW; i++) if (LEGAL_AW[i] == aw) aw_ok = 1'b1;
    for (int i = 0; i < N_LEGAL_DW; i++) if (LEGAL_DW[i] == dw) dw_ok = 1'b1;
    return aw_ok && dw_ok;
  endfunction

endpackage

// File: rtl/sram_macro_inst.sv
// One SRAM1RW<2**AW>x<DW> tile with the hard-macro pin set (all enables active-low).
// Behavioural body: synchronous write, read data registered on the CE edge.
module sram_macro_inst #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          CE,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] I,
  output logic [DW-1:0] O,
  input  logic          CSB,
  input  logic          OEB,
  input  logic          WEB
);

  // NOTE: the array has no reset; clearing it is the wrapper's zero-init job,
  // and a reset term here would stop it mapping onto a real memory.
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_o;

  always_ff @(posedge CE) begin
    if (!CSB && !WEB) r_mem[A] <= I;
    if (!CSB && WEB && !OEB) r_o <= r_mem[A];
  end

  assign O = r_o;

endmodule

// File: rtl/sram_tiled_wrapper.sv
// DEPTH x DATA_W 1RW memory built from ROWS x COLS SRAM macros, with valid/ready
// requests, per-column write mask, 2-cycle read pipeline and optional zero-init.
module sram_tiled_wrapper
  import sram_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int MACRO_ADDR_W = 12,
  parameter int MACRO_DATA_W = 16,
  parameter bit INIT_ZERO    = 1'b1,
  localparam int ROWS        = 2 ** (ADDR_W - MACRO_ADDR_W),
  localparam int COLS        = DATA_W / MACRO_DATA_W
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst,
  input  logic              RW0_valid,
  output logic              RW0_ready,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_wmode,
  input  logic [DATA_W-1:0] RW0_wdata,
  input  logic [COLS-1:0]   RW0_wmask,
  output logic              RW0_rvalid,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              init_done
);

  localparam int   ROW_W     = (ROWS > 1) ? ADDR_W - MACRO_ADDR_W : 1;
  localparam fsm_e RST_STATE = INIT_ZERO ? INIT : RUN;

  if (!legal_macro(MACRO_ADDR_W, MACRO_DATA_W) || ADDR_W < MACRO_ADDR_W ||
      (DATA_W % MACRO_DATA_W) != 0) begin : g_bad_geometry
    $error("sram_tiled_wrapper: unsupported geometry ADDR_W=%0d DATA_W=%0d macro %0dx%0d",
           ADDR_W, DATA_W, MACRO_ADDR_W, MACRO_DATA_W);
  end

  fsm_e                         r_state;
  fsm_e                         w_state_nxt;
  logic [MACRO_ADDR_W-1:0]      r_cnt;
  logic                         r_ready;
  logic                         r_init_done;

  logic                         r_s0_en;
  logic                         r_s0_wmode;
  logic [ADDR_W-1:0]            r_s0_addr;
  logic [DATA_W-1:0]            r_s0_wdata;
  logic [COLS-1:0]              r_s0_wmask;

  logic                         r_s1_rd;
  logic [ROW_W-1:0]             r_s1_row;
  logic                         r_rvalid;
  logic [DATA_W-1:0]            r_rdata;

  logic                         w_accept;
  logic                         w_init;
  logic [ROW_W-1:0]             w_row;
  logic [MACRO_ADDR_W-1:0]      w_macro_a;
  logic [ROWS-1:0][DATA_W-1:0]  w_row_o;
  logic [DATA_W-1:0]            w_rd_mux;

  assign w_accept  = RW0_valid & r_ready;
  assign w_init    = (r_state == INIT);
  assign w_macro_a = w_init ? r_cnt : r_s0_addr[MACRO_ADDR_W-1:0];

  if (ROWS > 1) begin : g_multi_row
    assign w_row    = r_s0_addr[ADDR_W-1:MACRO_ADDR_W];
    assign w_rd_mux = w_row_o[r_s1_row];
  end else begin : g_single_row
    assign w_row    = '0;
    assign w_rd_mux = w_row_o[0];
  end

  // FSM: zero-init sweep then steady-state service.
  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= (w_state_nxt == RUN);
      r_init_done <= (w_state_nxt == RUN);
      if (w_init) r_cnt <= r_cnt + 1'b1;
    end
  end

  // NOTE: assigning the default before the case keeps this purely combinational;
  // a path that leaves w_state_nxt unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (r_cnt == '1) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // Request pipeline: S0 holds the accepted request, S1 tracks the pending read.
  // NOTE: every register here uses <= so each stage samples the previous stage's
  // value from before the edge; blocking = would collapse the pipeline.
  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      r_s0_en    <= 1'b0;
      r_s0_wmode <= 1'b0;
      r_s0_addr  <= '0;
      r_s0_wdata <= '0;
      r_s0_wmask <= '0;
      r_s1_rd    <= 1'b0;
      r_s1_row   <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_s0_en <= w_accept;
      if (w_accept) begin
        r_s0_wmode <= RW0_wmode;
        r_s0_addr  <= RW0_addr;
        r_s0_wdata <= RW0_wdata;
        r_s0_wmask <= RW0_wmask;
      end
      r_s1_rd  <= r_s0_en & ~r_s0_wmode;
      r_s1_row <= w_row;
      r_rvalid <= r_s1_rd;
      if (r_s1_rd) r_rdata <= w_rd_mux;
    end
  end

  // Macro array; during INIT every tile writes zero at the sweep address.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic w_hit;
    assign w_hit = (w_row == ROW_W'(r));

    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic                    w_csb;
      logic                    w_web;
      logic                    w_oeb;
      logic [MACRO_DATA_W-1:0] w_i;
      logic [MACRO_DATA_W-1:0] w_o;

      assign w_csb = w_init ? 1'b0 : ~(r_s0_en & w_hit);
      assign w_web = w_init ? 1'b0 : ~(r_s0_en & r_s0_wmode & r_s0_wmask[c] & w_hit);
      assign w_oeb = w_init ? 1'b1 : ~(r_s0_en & ~r_s0_wmode & w_hit);
      assign w_i   = w_init ? '0 : r_s0_wdata[c*MACRO_DATA_W +: MACRO_DATA_W];
      assign w_row_o[r][c*MACRO_DATA_W +: MACRO_DATA_W] = w_o;

      sram_macro_inst #(
        .AW (MACRO_ADDR_W),
        .DW (MACRO_DATA_W)
      ) u_macro (
        .CE  (RW0_clk),
        .A   (w_macro_a),
        .I   (w_i),
        .O   (w_o),
        .CSB (w_csb),
        .OEB (w_oeb),
        .WEB (w_web)
      );
    end
  end

  assign RW0_ready  = r_ready;
  assign RW0_rvalid = r_rvalid;
  assign RW0_rdata  = r_rdata;
  assign init_done  = r_init_done;

endmodule

// File: tb/tb_sram_tiled_wrapper.sv
// Directed bench for sram_tiled_wrapper (13-bit address, 32-bit data, 4096x16 tiles).
// Covers zero-init timing, read latency, row select, masking, streaming and resets.
`timescale 1ns/1ps
module tb_sram_tiled_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [12:0] addr;
  logic        wmode;
  logic [31:0] wdata;
  logic [1:0]  wmask;
  logic        rvalid;
  logic [31:0] rdata;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_tiled_wrapper dut (
    .RW0_clk    (clk),
    .RW0_rst    (rst),
    .RW0_valid  (valid),
    .RW0_ready  (ready),
    .RW0_addr   (addr),
    .RW0_wmode  (wmode),
    .RW0_wdata  (wdata),
    .RW0_wmask  (wmask),
    .RW0_rvalid (rvalid),
    .RW0_rdata  (rdata),
    .init_done  (init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from reset release until ready rises, and rvalid pulses seen meanwhile.
  task automatic wait_init(input string tag, output int n_rv);
    int n;
    n    = 0;
    n_rv = 0;
    while (!ready && n < 5000) begin
      tick();
      n++;
      if (rvalid) n_rv++;
    end
    check({tag, "_cycles"}, n, 4096);
    check({tag, "_done"}, init_done, 1);
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [1:0] m);
    valid = 1'b1;
    wmode = 1'b1;
    addr  = a;
    wdata = d;
    wmask = m;
    tick();
    valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [12:0] a, input logic [31:0] exp);
    valid = 1'b1;
    wmode = 1'b0;
    addr  = a;
    tick();
    valid = 1'b0;
    tick();
    check({tag, "_rv_early"}, rvalid, 0);
    tick();
    check({tag, "_rv"}, rvalid, 1);
    check({tag, "_data"}, rdata, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stream_d [8];
    int          n_rv;

    rst   = 1'b1;
    valid = 1'b0;
    wmode = 1'b0;
    addr  = '0;
    wdata = '0;
    wmask = '0;
    repeat (3) tick();

    check("rst_ready", ready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_init_done", init_done, 0);

    rst = 1'b0;
    wait_init("init", n_rv);
    check("init_ready", ready, 1);

    rd_chk("rd_top_zero", 13'h1FFF, 32'h0000_0000);

    // Write then read the same address in consecutive cycles.
    valid = 1'b1;
    wmode = 1'b1;
    addr  = 13'h0005;
    wdata = 32'h1234_ABCD;
    wmask = 2'b11;
    tick();
    wmode = 1'b0;
    tick();
    valid = 1'b0;
    check("b2b_rv_e1", rvalid, 0);
    tick();
    check("b2b_rv_e2", rvalid, 0);
    tick();
    check("b2b_rv_e3", rvalid, 1);
    check("b2b_data", rdata, 32'h1234_ABCD);
    tick();
    check("b2b_rv_single", rvalid, 0);
    check("b2b_data_hold", rdata, 32'h1234_ABCD);

    wr(13'h0005, 32'hAAAA_5555, 2'b11);
    wr(13'h1005, 32'h5555_AAAA, 2'b11);
    tick();
    check("wr_no_rvalid", rvalid, 0);
    rd_chk("row0", 13'h0005, 32'hAAAA_5555);
    rd_chk("row1", 13'h1005, 32'h5555_AAAA);

    wr(13'h0005, 32'hFFFF_FFFF, 2'b01);
    rd_chk("mask_lo", 13'h0005, 32'hAAAA_FFFF);
    wr(13'h1005, 32'h0000_0000, 2'b00);
    rd_chk("mask_none", 13'h1005, 32'h5555_AAAA);
    wr(13'h1005, 32'h0123_4567, 2'b10);
    rd_chk("mask_hi", 13'h1005, 32'h0123_AAAA);

    stream_d = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                 32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      wmode = 1'b1;
      addr  = 13'(i);
      wdata = stream_d[i];
      wmask = 2'b11;
      tick();
    end
    for (int t = 0; t < 11; t++) begin
      if (t < 8) begin
        valid = 1'b1;
        wmode = 1'b0;
        addr  = 13'(t);
      end else begin
        valid = 1'b0;
      end
      tick();
      if (t >= 2 && t < 10) begin
        check($sformatf("stream_rv%0d", t - 2), rvalid, 1);
        check($sformatf("stream_d%0d", t - 2), rdata, stream_d[t-2]);
      end else begin
        check($sformatf("stream_idle%0d", t), rvalid, 0);
      end
    end

    // Reset at cycle 100 of init: the sweep must start over.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (100) tick();
    check("midinit_ready", ready, 0);
    check("midinit_done", init_done, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init("reinit", n_rv);
    rd_chk("reinit_zero", 13'h0005, 32'h0000_0000);

    // Reset the cycle after a read is accepted: that read never completes.
    valid = 1'b1;
    wmode = 1'b0;
    addr  = 13'h0003;
    tick();
    valid = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    check("midrd_rdata", rdata, 0);
    wait_init("midrd_init", n_rv);
    check("midrd_no_rvalid", n_rv, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
